// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit 7-segment display. Inputs are
//   captured into a staging buffer on load_in and promoted to a shadow buffer
//   only at frame end, so a frame never shows a mix of old and new values.
//   Each digit slot starts with a blank interval (all selects off) to avoid
//   ghosting. Leading-zero suppression, blinking, optional hex glyphs and
//   output polarity are applied before the output registers.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   digits_in    packed 4-bit codes, digit i at [4i+3:4i] (digit 0 = LSD)
//   dp_in        decimal point per digit
//   blank_in     force digit off
//   blink_in     digit blinks
//   lz_en        leading-zero suppression enable
//   load_in      capture strobe for all inputs above
//   seg_out      segments {g,f,e,d,c,b,a}
//   dp_out       decimal point
//   dig_sel_out  one-hot digit select, or all inactive
//   frame_done   one-cycle pulse after the last cycle of each scan frame
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS     = 6,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 60,
  parameter bit          HEX_EN       = 1'b0,
  parameter bit          SEG_ACT_LOW  = 1'b0,
  parameter bit          DIG_ACT_LOW  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic                  lz_en,
  input  logic                  load_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   dig_sel_out,
  output logic                  frame_done
);

  localparam int unsigned SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] LastSlot  = SW'(TICK_DIV - 1);
  localparam logic [SW-1:0] BlankEnd  = SW'(BLANK_CYC);
  localparam logic [IW-1:0] LastDigit = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] LastFrame = FW'(BLINK_FRAMES - 1);

  // Staging buffer (written by load_in) and shadow buffer (drives the scan)
  logic [N_DIGITS-1:0][3:0] stg_digits_q, shd_digits_q;
  logic [N_DIGITS-1:0]      stg_dp_q, shd_dp_q;
  logic [N_DIGITS-1:0]      stg_blank_q, shd_blank_q;
  logic [N_DIGITS-1:0]      stg_blink_q, shd_blink_q;
  logic                     stg_lz_q, shd_lz_q;
  logic                     pending_q;

  // Scan state
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IW-1:0] digit_idx_q, digit_idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          slot_wrap, frame_end;

  assign slot_wrap = (slot_cnt_q == LastSlot);
  assign frame_end = slot_wrap && (digit_idx_q == LastDigit);

  always_comb begin
    slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_idx_d   = digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_wrap) begin
      digit_idx_d = (digit_idx_q == LastDigit) ? '0 : digit_idx_q + IW'(1);
    end
    if (frame_end) begin
      if (frame_cnt_q == LastFrame) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // A load coinciding with frame end still lands in staging and stays pending;
  // the shadow takes whatever staging held before that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_digits_q <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      stg_blink_q  <= '0;
      stg_lz_q     <= 1'b0;
      shd_digits_q <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      shd_blink_q  <= '0;
      shd_lz_q     <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      if (load_in) begin
        stg_digits_q <= digits_in;
        stg_dp_q     <= dp_in;
        stg_blank_q  <= blank_in;
        stg_blink_q  <= blink_in;
        stg_lz_q     <= lz_en;
      end
      if (frame_end && pending_q) begin
        shd_digits_q <= stg_digits_q;
        shd_dp_q     <= stg_dp_q;
        shd_blank_q  <= stg_blank_q;
        shd_blink_q  <= stg_blink_q;
        shd_lz_q     <= stg_lz_q;
      end
      pending_q <= load_in | (pending_q & ~frame_end);
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1101111;
      4'hA:    g = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'hB:    g = HEX_EN ? 7'b1111100 : 7'b0000000;
      4'hC:    g = HEX_EN ? 7'b0111001 : 7'b0000000;
      4'hD:    g = HEX_EN ? 7'b1011110 : 7'b0000000;
      4'hE:    g = HEX_EN ? 7'b1111001 : 7'b0000000;
      default: g = HEX_EN ? 7'b1110001 : 7'b0000000;
    endcase
    return g;
  endfunction

  // Walk from the most significant digit down; a digit is suppressed while
  // it and everything above it are zero. Digit 0 always shows.
  logic [N_DIGITS-1:0] lz_off;
  logic                zero_above;

  always_comb begin
    zero_above = 1'b1;
    lz_off     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (shd_digits_q[i] == 4'd0);
      if (i != 0) begin
        lz_off[i] = shd_lz_q & zero_above;
      end
    end
  end

  logic [3:0]          code;
  logic                digit_off;
  logic [6:0]          seg_d;
  logic                dp_d;
  logic [N_DIGITS-1:0] sel_d;

  always_comb begin
    code      = shd_digits_q[digit_idx_q];
    digit_off = shd_blank_q[digit_idx_q]
              | (blink_phase_q & shd_blink_q[digit_idx_q])
              | (!HEX_EN && (code > 4'd9));
    // Leading-zero suppression kills segments only; the dp survives
    seg_d     = (digit_off | lz_off[digit_idx_q]) ? 7'b0000000 : glyph(code);
    dp_d      = ~digit_off & shd_dp_q[digit_idx_q];
    sel_d     = '0;
    if (slot_cnt_q >= BlankEnd) begin
      sel_d[digit_idx_q] = 1'b1;
    end
  end

  // Polarity is folded in before the flops so the pins come straight off a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= {7{SEG_ACT_LOW}};
      dp_out      <= SEG_ACT_LOW;
      dig_sel_out <= {N_DIGITS{DIG_ACT_LOW}};
      frame_done  <= 1'b0;
    end else begin
      seg_out     <= SEG_ACT_LOW ? ~seg_d : seg_d;
      dp_out      <= SEG_ACT_LOW ? ~dp_d : dp_d;
      dig_sel_out <= DIG_ACT_LOW ? ~sel_d : sel_d;
      frame_done  <= frame_end;
    end
  end

endmodule
